// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter.
// Optional counters: MEM_ARB_PERF_CNT_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_e;

  localparam logic [3:0] BE_ZERO = 4'b0000;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory signals shared by the arbiter and its users.
// Optional counters: MEM_ARB_PERF_CNT_EN.
interface mem_arbiter_if #(
  parameter int ADDR_W = 14
);
  logic              if_req_i;
  logic [31:0]       if_addr_i;
  logic [31:0]       if_rdata_o;
  logic              if_valid_o;
  logic              d_req_i;
  logic              d_we_i;
  logic [31:0]       d_addr_i;
  logic [31:0]       d_wdata_i;
  logic [3:0]        d_be_i;
  logic [31:0]       d_rdata_o;
  logic              d_valid_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [3:0]        mem_be_o;
  logic [31:0]       mem_rdata_i;

  modport master (
    output if_req_i, if_addr_i,
    output d_req_i, d_we_i, d_addr_i,
    output d_wdata_i, d_be_i,
    output mem_rdata_i,
    input  if_rdata_o, if_valid_o,
    input  d_rdata_o, d_valid_o,
    input  mem_req_o, mem_we_o,
    input  mem_addr_o, mem_wdata_o,
    input  mem_be_o
  );

  modport slave (
    input  if_req_i, if_addr_i,
    input  d_req_i, d_we_i, d_addr_i,
    input  d_wdata_i, d_be_i,
    input  mem_rdata_i,
    output if_rdata_o, if_valid_o,
    output d_rdata_o, d_valid_o,
    output mem_req_o, mem_we_o,
    output mem_addr_o, mem_wdata_o,
    output mem_be_o
  );
endinterface

// File: rtl/mem_arb_perf.sv
// Grant and conflict counters for the memory arbiter.
// Built only with MEM_ARB_PERF_CNT_EN.
module mem_arb_perf (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_grant_i,
  input  logic        d_grant_i,
  input  logic        conflict_i,
  output logic [31:0] if_cnt_o,
  output logic [31:0] d_cnt_o,
  output logic [31:0] conflict_cnt_o
);

  logic [31:0] if_cnt_q, d_cnt_q, cf_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      if_cnt_q <= '0;
      d_cnt_q  <= '0;
      cf_cnt_q <= '0;
    end else begin
      if (if_grant_i) if_cnt_q <= if_cnt_q + 32'd1;
      if (d_grant_i)  d_cnt_q  <= d_cnt_q + 32'd1;
      if (conflict_i) cf_cnt_q <= cf_cnt_q + 32'd1;
    end
  end

  assign if_cnt_o       = if_cnt_q;
  assign d_cnt_o        = d_cnt_q;
  assign conflict_cnt_o = cf_cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter in front of one synchronous memory.
// Optional counters: MEM_ARB_PERF_CNT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 14,
  parameter int DATA_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  mem_arbiter_if.slave bus,
  output logic [31:0] perf_if_cnt_o,
  output logic [31:0] perf_d_cnt_o,
  output logic [31:0] perf_conflict_cnt_o
);

  localparam int BW = $clog2(DATA_BURST_MAX + 1);
  localparam logic [BW-1:0] BMAX = BW'(DATA_BURST_MAX);

  state_e            state_q;
  owner_e            owner_q;
  logic [BW-1:0]     burst_q, burst_d;
  logic              req_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic              idle, d_win, if_win;
  logic              resp_if, resp_d;
  logic              unused_addr;

  assign idle = (state_q == S_IDLE);

  // Data also wins at the burst limit if fetch has gone away.
  assign d_win = idle && bus.d_req_i &&
                 ((burst_q < BMAX) || !bus.if_req_i);
  assign if_win = idle && !d_win && bus.if_req_i;

  always_comb begin
    burst_d = burst_q;
    if (if_win) begin
      burst_d = '0;
    end else if (d_win) begin
      if (!bus.if_req_i)       burst_d = '0;
      else if (burst_q < BMAX) burst_d = burst_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= OWN_IF;
      burst_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= BE_ZERO;
    end else begin
      req_q   <= 1'b0;
      burst_q <= burst_d;
      unique case (state_q)
        S_IDLE: begin
          if (d_win) begin
            owner_q <= OWN_D;
            req_q   <= 1'b1;
            we_q    <= bus.d_we_i;
            addr_q  <= bus.d_addr_i[ADDR_W+1:2];
            wdata_q <= bus.d_wdata_i;
            be_q    <= bus.d_be_i;
            state_q <= S_ACCESS;
          end else if (if_win) begin
            owner_q <= OWN_IF;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= bus.if_addr_i[ADDR_W+1:2];
            wdata_q <= '0;
            be_q    <= BE_ZERO;
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: state_q <= S_RESP;
        S_RESP:   state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign resp_if = (state_q == S_RESP) && (owner_q == OWN_IF);
  assign resp_d  = (state_q == S_RESP) && (owner_q == OWN_D);

  assign bus.mem_req_o   = req_q;
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.mem_be_o    = be_q;

  assign bus.if_valid_o = resp_if;
  assign bus.d_valid_o  = resp_d;
  assign bus.if_rdata_o = resp_if ? bus.mem_rdata_i : '0;
  assign bus.d_rdata_o  = resp_d ? bus.mem_rdata_i : '0;

  assign unused_addr = ^{bus.if_addr_i[1:0],
                         bus.if_addr_i[31:ADDR_W+2],
                         bus.d_addr_i[1:0],
                         bus.d_addr_i[31:ADDR_W+2]};

`ifdef MEM_ARB_PERF_CNT_EN
  logic conflict;
  assign conflict = idle && bus.if_req_i && bus.d_req_i;

  mem_arb_perf u_perf (
    .clk           (clk),
    .reset         (reset),
    .if_grant_i    (if_win),
    .d_grant_i     (d_win),
    .conflict_i    (conflict),
    .if_cnt_o      (perf_if_cnt_o),
    .d_cnt_o       (perf_d_cnt_o),
    .conflict_cnt_o(perf_conflict_cnt_o)
  );
`else
  assign perf_if_cnt_o       = '0;
  assign perf_d_cnt_o        = '0;
  assign perf_conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural memory.
// Counter checks follow MEM_ARB_PERF_CNT_EN.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(14)) bus();
  logic [31:0] pif, pd, pc;

  mem_arbiter #(
    .ADDR_W(14),
    .DATA_BURST_MAX(4)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .bus                (bus),
    .perf_if_cnt_o      (pif),
    .perf_d_cnt_o       (pd),
    .perf_conflict_cnt_o(pc)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] mem [0:16383];
  bit loaded = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!loaded) begin
      mem[4]     <= 32'h0000_0013;
      mem[64]    <= 32'h0;
      mem[128]   <= 32'h0;
      mem[256]   <= 32'h0000_0093;
      mem[512]   <= 32'h55AA_55AA;
      mem[16383] <= 32'hCAFE_F00D;
      loaded     <= 1'b1;
    end else if (bus.mem_req_o) begin
      bus.mem_rdata_i <= mem[bus.mem_addr_o];
      if (bus.mem_we_o)
        for (int b = 0; b < 4; b++)
          if (bus.mem_be_o[b])
            mem[bus.mem_addr_o][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
    end
  end

  logic [31:0] ifq[$];
  logic [31:0] dq[$];
  bit          dchk[$];
  logic [13:0] glog[$];
  logic [3:0]  gbe[$];
  bit          gwe[$];
  int          gcyc[$];
  int          ivcyc[$];
  int          dvcyc[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr_logs();
    glog.delete(); gbe.delete(); gwe.delete(); gcyc.delete();
    ivcyc.delete(); dvcyc.delete();
  endtask

  // Called at each negedge: log grants, score completions.
  task automatic observe(input bit hold);
    logic [31:0] e;
    bit c;
    if (bus.mem_req_o) begin
      glog.push_back(bus.mem_addr_o);
      gbe.push_back(bus.mem_be_o);
      gwe.push_back(bus.mem_we_o);
      gcyc.push_back(cyc);
    end
    if (bus.if_valid_o) begin
      if (!bus.if_req_i || ifq.size() == 0) begin
        chk("if_spurious_valid", 32'd1, 32'd0);
      end else begin
        e = ifq.pop_front();
        chk("if_rdata", bus.if_rdata_o, e);
        ivcyc.push_back(cyc);
        if (hold) ifq.push_back(e);
        else bus.if_req_i = 1'b0;
      end
    end
    if (bus.d_valid_o) begin
      if (!bus.d_req_i || dq.size() == 0) begin
        chk("d_spurious_valid", 32'd1, 32'd0);
      end else begin
        e = dq.pop_front();
        c = dchk.pop_front();
        if (c) chk("d_rdata", bus.d_rdata_o, e);
        dvcyc.push_back(cyc);
        if (hold) begin
          dq.push_back(e);
          dchk.push_back(c);
        end else begin
          bus.d_req_i = 1'b0;
        end
      end
    end
  endtask

  task automatic txn(input bit fi, input logic [31:0] fa,
                     input logic [31:0] fexp, input bit di,
                     input bit we, input logic [31:0] da,
                     input logic [31:0] wd, input logic [3:0] be,
                     input logic [31:0] dexp);
    int n;
    n = 0;
    clr_logs();
    @(posedge clk); #1;
    if (fi) begin
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = fa;
      ifq.push_back(fexp);
    end
    if (di) begin
      bus.d_req_i   = 1'b1;
      bus.d_we_i    = we;
      bus.d_addr_i  = da;
      bus.d_wdata_i = wd;
      bus.d_be_i    = be;
      dq.push_back(dexp);
      dchk.push_back(!we);
    end
    while ((bus.if_req_i || bus.d_req_i) && n < 20) begin
      @(negedge clk);
      n++;
      observe(1'b0);
    end
    if (bus.if_req_i || bus.d_req_i)
      chk("txn_timeout", 32'd1, 32'd0);
    bus.if_req_i = 1'b0;
    bus.d_req_i  = 1'b0;
    ifq.delete(); dq.delete(); dchk.delete();
  endtask

  typedef struct {
    bit          fi;
    logic [31:0] fa;
    logic [31:0] fexp;
    bit          di;
    bit          we;
    logic [31:0] da;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] dexp;
    logic [13:0] maddr;
    logic [3:0]  mbe;
    bit          mwe;
  } vec_t;

  vec_t tv[9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, n;
    bit seen;
    bus.if_req_i  = 1'b0;
    bus.if_addr_i = '0;
    bus.d_req_i   = 1'b0;
    bus.d_we_i    = 1'b0;
    bus.d_addr_i  = '0;
    bus.d_wdata_i = '0;
    bus.d_be_i    = '0;

    tv[0] = '{1'b1, 32'h10, 32'h13, 1'b0, 1'b0, 32'h0, 32'h0,
              4'h0, 32'h0, 14'd4, 4'h0, 1'b0};
    tv[1] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF,
              4'b0011, 32'h0, 14'd64, 4'b0011, 1'b1};
    tv[2] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0,
              4'hF, 32'h0000BEEF, 14'd64, 4'hF, 1'b0};
    tv[3] = '{1'b1, 32'h13, 32'h13, 1'b0, 1'b0, 32'h0, 32'h0,
              4'h0, 32'h0, 14'd4, 4'h0, 1'b0};
    tv[4] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h3FFFC, 32'h0,
              4'hF, 32'hCAFEF00D, 14'h3FFF, 4'hF, 1'b0};
    tv[5] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h201, 32'h12345678,
              4'hF, 32'h0, 14'd128, 4'hF, 1'b1};
    tv[6] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0,
              4'hF, 32'h12345678, 14'd128, 4'hF, 1'b0};
    tv[7] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hAABBCCDD,
              4'b1100, 32'h0, 14'd128, 4'b1100, 1'b1};
    tv[8] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h202, 32'h0,
              4'hF, 32'hAABB5678, 14'd128, 4'hF, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_ctl", {29'd0, bus.mem_req_o, bus.mem_we_o,
                        |bus.mem_be_o}, 32'd0);
    chk("rst_mem_addr", {18'd0, bus.mem_addr_o}, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata_o, 32'd0);
    chk("rst_valids", {30'd0, bus.if_valid_o, bus.d_valid_o}, 32'd0);
    chk("rst_if_rdata", bus.if_rdata_o, 32'd0);
    chk("rst_d_rdata", bus.d_rdata_o, 32'd0);
    chk("rst_perf", pif | pd | pc, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      txn(tv[i].fi, tv[i].fa, tv[i].fexp, tv[i].di, tv[i].we,
          tv[i].da, tv[i].wd, tv[i].be, tv[i].dexp);
      chk($sformatf("v%0d_grants", i), glog.size(), 32'd1);
      if (glog.size() > 0) begin
        chk($sformatf("v%0d_maddr", i), {18'd0, glog[0]},
            {18'd0, tv[i].maddr});
        chk($sformatf("v%0d_mbe", i), {28'd0, gbe[0]},
            {28'd0, tv[i].mbe});
        chk($sformatf("v%0d_mwe", i), {31'd0, gwe[0]},
            {31'd0, tv[i].mwe});
      end
    end

    // Back-to-back fetches: latency and 3-cycle throughput.
    clr_logs();
    @(posedge clk); #1;
    s = cyc;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h10;
    ifq.push_back(32'h13);
    n = 0;
    while (ivcyc.size() < 2 && n < 20) begin
      @(negedge clk);
      n++;
      observe(1'b1);
    end
    bus.if_req_i = 1'b0;
    ifq.delete();
    chk("fetch_b2b_count", ivcyc.size(), 32'd2);
    if (gcyc.size() >= 2 && ivcyc.size() >= 1) begin
      chk("fetch_req_latency", gcyc[0] - s, 32'd1);
      chk("fetch_valid_latency", ivcyc[0] - gcyc[0], 32'd1);
      chk("fetch_next_req", gcyc[1] - gcyc[0], 32'd3);
    end

    // Continuous contention: D,D,D,D,IF repeating.
    clr_logs();
    @(posedge clk); #1;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h400;
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = 1'b0;
    bus.d_addr_i  = 32'h800;
    bus.d_be_i    = 4'hF;
    ifq.push_back(32'h93);
    dq.push_back(32'h55AA55AA);
    dchk.push_back(1'b1);
    n = 0;
    while (ivcyc.size() + dvcyc.size() < 10 && n < 60) begin
      @(negedge clk);
      n++;
      observe(1'b1);
    end
    bus.if_req_i = 1'b0;
    bus.d_req_i  = 1'b0;
    ifq.delete(); dq.delete(); dchk.delete();
    chk("contend_grants", glog.size(), 32'd10);
    for (int i = 0; i < 10 && i < glog.size(); i++)
      chk($sformatf("contend_order%0d", i), {18'd0, glog[i]},
          (i % 5 == 4) ? 32'd256 : 32'd512);

    // Simultaneous requests from idle: data first, fetch 3 later.
    txn(1'b1, 32'h400, 32'h93, 1'b1, 1'b0, 32'h800, 32'h0,
        4'hF, 32'h55AA55AA);
    chk("simul_grants", glog.size(), 32'd2);
    if (glog.size() == 2) begin
      chk("simul_first_d", {18'd0, glog[0]}, 32'd512);
      chk("simul_second_if", {18'd0, glog[1]}, 32'd256);
      chk("simul_gap", gcyc[1] - gcyc[0], 32'd3);
    end

    // Reset during ACCESS of a load.
    @(posedge clk); #1;
    bus.d_req_i  = 1'b1;
    bus.d_we_i   = 1'b0;
    bus.d_addr_i = 32'h800;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 5) begin
      @(negedge clk);
      n++;
      seen = bus.mem_req_o;
    end
    chk("rstacc_reached", {31'd0, seen}, 32'd1);
    reset = 1'b1;
    bus.d_req_i = 1'b0;
    @(posedge clk); #1;
    chk("rstacc_mem", {bus.mem_req_o, bus.mem_we_o, bus.mem_be_o,
                       12'd0, bus.mem_addr_o}, 32'd0);
    chk("rstacc_wdata", bus.mem_wdata_o, 32'd0);
    chk("rstacc_rdata", bus.d_rdata_o | bus.if_rdata_o, 32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.d_valid_o || bus.if_valid_o) seen = 1'b1;
    end
    chk("rstacc_no_valid", {31'd0, seen}, 32'd0);
    reset = 1'b0;
    txn(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0,
        4'hF, 32'hAABB5678);
    chk("rstacc_after_grants", glog.size(), 32'd1);

    // Counters: 10 fetches, 5 loads, 3 of them contended.
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (7) txn(1'b1, 32'h10, 32'h13, 1'b0, 1'b0, 32'h0, 32'h0,
                   4'h0, 32'h0);
    repeat (2) txn(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h800, 32'h0,
                   4'hF, 32'h55AA55AA);
    repeat (3) txn(1'b1, 32'h400, 32'h93, 1'b1, 1'b0, 32'h800, 32'h0,
                   4'hF, 32'h55AA55AA);
    @(negedge clk);
`ifdef MEM_ARB_PERF_CNT_EN
    chk("perf_if", pif, 32'd10);
    chk("perf_d", pd, 32'd5);
    chk("perf_conflict_ge3", {31'd0, pc >= 32'd3}, 32'd1);
`else
    chk("perf_if", pif, 32'd0);
    chk("perf_d", pd, 32'd0);
    chk("perf_conflict", pc, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
